// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Which requester wins the memory in the current IDLE cycle
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_IF   = 2'd1,
        SEL_DM   = 2'd2
    } port_sel_t;

    // Instruction fetches are always full-word accesses
    localparam logic [2:0] FETCH_MODE = 3'b010;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational grant decision: data wins a tie unless fetch has been
// passed over MAX_DATA_STREAK times in a row.
module arb_priority_sel
    import mem_arb_pkg::*;
(
    input  logic      if_req,
    input  logic      dm_req,
    input  logic      streak_full,
    output port_sel_t sel
);

    // Priority pick between the two requesters
    always_comb begin
        sel = SEL_NONE;
        if (dm_req && !(if_req && streak_full)) begin
            sel = SEL_DM;
        end else if (if_req) begin
            sel = SEL_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and the MEM stage.
// Each transaction runs IDLE -> GRANT_x -> RESP; a watchdog aborts a grant
// that never sees mem_ack and raises a sticky bus_err.
//
// state   | meaning
// IDLE    | arbitrate; latch winner's command into mem_* on exit
// GRANT_I | fetch read outstanding, waiting for mem_ack or timeout
// GRANT_D | data load/store outstanding, waiting for mem_ack or timeout
// RESP    | one-cycle ready pulse to the serviced port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    input  logic [2:0]       dm_mode,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_ready,
    output logic             stall_if,
    output logic             stall_dm,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [2:0]       mem_mode,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             bus_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state, state_nxt;
    port_sel_t     sel;
    logic [SW-1:0] streak;
    logic [TW-1:0] to_cnt;
    logic          streak_full;
    logic          in_grant;
    logic          ack_seen;
    logic          txn_done;
    logic          start_if;
    logic          start_dm;

    assign streak_full = (streak == STREAK_MAX);
    assign in_grant    = (state == GRANT_I) || (state == GRANT_D);
    // mem_ack only counts while a request is actually outstanding
    assign ack_seen    = mem_req && mem_ack;
    assign txn_done    = ack_seen || (to_cnt == TO_LAST);
    assign start_if    = (state == IDLE) && (sel == SEL_IF);
    assign start_dm    = (state == IDLE) && (sel == SEL_DM);

    assign stall_if = if_req && !if_ready;
    assign stall_dm = dm_req && !dm_ready;

    arb_priority_sel u_sel (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .streak_full (streak_full),
        .sel         (sel)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arbitrate in IDLE, leave GRANT on ack or timeout, single RESP cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sel == SEL_IF) begin
                    state_nxt = GRANT_I;
                end else if (sel == SEL_DM) begin
                    state_nxt = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (txn_done) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory command: latched from the winner on grant entry, held until completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mode  <= '0;
        end else if (start_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_mode  <= FETCH_MODE;
        end else if (start_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_mode  <= dm_mode;
        end else if (in_grant && txn_done) begin
            mem_req   <= 1'b0;
        end
    end

    // Fetch-starvation streak and per-grant watchdog counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            streak <= '0;
            to_cnt <= '0;
        end else begin
            if (start_if) begin
                streak <= '0;
            end else if (start_dm) begin
                if (!if_req) begin
                    streak <= '0;
                end else if (!streak_full) begin
                    streak <= streak + 1'b1;
                end
            end
            if (in_grant && !txn_done) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Completion: ready pulse, read data capture (zero on abort), sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            bus_err  <= 1'b0;
        end else begin
            if_ready <= (state == GRANT_I) && txn_done;
            dm_ready <= (state == GRANT_D) && txn_done;
            if ((state == GRANT_I) && txn_done) begin
                if_rdata <= ack_seen ? mem_rdata : '0;
            end
            if ((state == GRANT_D) && txn_done) begin
                dm_rdata <= ack_seen ? mem_rdata : '0;
            end
            if (in_grant && txn_done && !ack_seen) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level schedule model
// predicts, for each request seen while the arbiter is free, the winner,
// the grant window, the ready cycle and the returned data.
module tb_mem_port_arbiter;

    localparam int W    = 32;
    localparam int MAXS = 4;
    localparam int TOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we, mem_ack;
    logic [W-1:0]  if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [2:0]    dm_mode;
    logic [W-1:0]  if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic          if_ready, dm_ready, stall_if, stall_dm, mem_req, mem_we, bus_err;
    logic [2:0]    mem_mode;

    mem_port_arbiter #(.WIDTH(W), .MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_mode(dm_mode), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mode(mem_mode), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // schedule model of the single in-flight transaction
    int         next_idle = 0;
    int         win_start = -100, win_end = -100, ready_cyc = -100;
    bit         win_dm = 1'b0, win_to = 1'b0;
    logic       exp_we = 1'b0;
    logic [W-1:0] exp_addr = '0, exp_wdata = '0, ack_data = '0;
    logic [2:0] exp_mode = '0;
    logic [W-1:0] exp_if_rdata = '0, exp_dm_rdata = '0;
    bit         exp_bus_err = 1'b0;
    int         streak = 0;

    // requester state and stimulus knobs
    bit if_act = 1'b0, dm_act = 1'b0, if_busy = 1'b0, dm_busy = 1'b0;
    int p_if = 0, p_dm = 0, lat_max = 0, spur_pct = 0, drop_pct = 0;
    bit force_to = 1'b0, force_ack = 1'b0, do_reset = 1'b0;

    task automatic chk_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic set_phase(input int pi, input int pd, input int lm, input int sp, input int dp);
        p_if = pi; p_dm = pd; lat_max = lm; spur_pct = sp; drop_pct = dp;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check stalls
    task automatic step();
        bit in_win, exp_ifr, exp_dmr, dm_win;
        int lat;
        @(negedge clk);
        in_win  = (cyc >= win_start) && (cyc <= win_end);
        exp_ifr = (cyc == ready_cyc) && !win_dm;
        exp_dmr = (cyc == ready_cyc) && win_dm;
        if (cyc == ready_cyc) begin
            if (win_dm) exp_dm_rdata = win_to ? '0 : ack_data;
            else        exp_if_rdata = win_to ? '0 : ack_data;
            if (win_to) exp_bus_err = 1'b1;
        end
        chk_val("mem_req", mem_req, in_win);
        if (in_win) begin
            chk_val("mem_we", mem_we, exp_we);
            chk_val("mem_addr", mem_addr, exp_addr);
            chk_val("mem_mode", mem_mode, exp_mode);
            if (win_dm) chk_val("mem_wdata", mem_wdata, exp_wdata);
        end
        chk_val("if_ready", if_ready, exp_ifr);
        chk_val("dm_ready", dm_ready, exp_dmr);
        chk_val("if_rdata", if_rdata, exp_if_rdata);
        chk_val("dm_rdata", dm_rdata, exp_dm_rdata);
        chk_val("bus_err", bus_err, exp_bus_err);

        if (do_reset) begin
            rst = 1'b0;
            if_act = 1'b0; dm_act = 1'b0; if_busy = 1'b0; dm_busy = 1'b0;
            if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
            win_start = -100; win_end = -100; ready_cyc = -100;
            next_idle = cyc + 1; streak = 0;
            exp_if_rdata = '0; exp_dm_rdata = '0; exp_bus_err = 1'b0;
        end else begin
            rst = 1'b1;
            if (ready_cyc == cyc - 1) begin
                if (win_dm) begin dm_busy = 1'b0; dm_act = 1'b0; end
                else        begin if_busy = 1'b0; if_act = 1'b0; end
            end
            if (if_busy && if_act && cyc < ready_cyc && $urandom_range(99) < drop_pct) if_act = 1'b0;
            if (dm_busy && dm_act && cyc < ready_cyc && $urandom_range(99) < drop_pct) dm_act = 1'b0;
            if (!if_act && !if_busy && $urandom_range(99) < p_if) begin
                if_act  = 1'b1;
                if_addr = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
            end
            if (!dm_act && !dm_busy && $urandom_range(99) < p_dm) begin
                dm_act   = 1'b1;
                dm_we    = $urandom_range(1);
                dm_addr  = $urandom() & 32'h7FFF_FFFF;
                dm_wdata = $urandom();
                dm_mode  = 3'($urandom_range(7));
            end
            if_req = if_act;
            dm_req = dm_act;

            if (cyc >= next_idle && (if_act || dm_act)) begin
                dm_win = dm_act && !(if_act && streak == MAXS);
                if (dm_win) begin
                    streak    = if_act ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    exp_we    = dm_we;
                    exp_addr  = dm_addr;
                    exp_wdata = dm_wdata;
                    exp_mode  = dm_mode;
                    dm_busy   = 1'b1;
                end else begin
                    streak    = 0;
                    exp_we    = 1'b0;
                    exp_addr  = if_addr;
                    exp_mode  = 3'b010;
                    if_busy   = 1'b1;
                end
                win_dm    = dm_win;
                win_to    = force_to;
                force_to  = 1'b0;
                lat       = win_to ? TOUT - 1 : int'($urandom_range(lat_max));
                win_start = cyc + 1;
                win_end   = cyc + 1 + lat;
                ready_cyc = cyc + 2 + lat;
                next_idle = cyc + 3 + lat;
                ack_data  = $urandom();
            end

            if (in_win && cyc == win_end && !win_to) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_data;
            end else if (force_ack || (!in_win && $urandom_range(99) < spur_pct)) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom();
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
            end
        end
        #1;
        chk_val("stall_if", stall_if, if_req && !exp_ifr);
        chk_val("stall_dm", stall_dm, dm_req && !exp_dmr);
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_mode = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // both ports always requesting, zero-wait memory: streak and back-to-back
        set_phase(100, 100, 0, 0, 0);
        repeat (60) step();
        // mostly fetch traffic with memory wait states
        set_phase(70, 0, 3, 0, 0);
        repeat (60) step();
        // mixed traffic, stray acks, occasional early request drop
        set_phase(60, 60, 4, 10, 5);
        repeat (400) step();
        // next transaction never acked
        force_to = 1'b1;
        set_phase(0, 100, 0, 0, 0);
        repeat (30) step();
        set_phase(50, 50, 3, 10, 5);
        repeat (200) step();

        // reset while a data grant is outstanding, then a late ack
        set_phase(0, 100, 3, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (win_dm && cyc >= win_start && cyc <= win_end) found = 1'b1;
            else step();
        end
        chk_val("reach_grant_d", found, 1);
        do_reset = 1'b1;
        step();
        do_reset = 1'b0;
        set_phase(0, 0, 0, 0, 0);
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        repeat (5) step();

        set_phase(60, 60, 4, 10, 5);
        repeat (300) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the fetch stage (instruction reads) and the MEM stage (data loads/stores).
- Arbitrates between them, sequences each transaction through a request/acknowledge handshake with the backing memory, and returns read data with a one-cycle ready pulse.
- Supplies per-port stall signals to the hazard unit.
- Includes a starvation guard for fetch and a transaction watchdog.

Parameters:
- WIDTH, 32, address and data width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced (must be ≥1).
- TIMEOUT_CYCLES, 64, cycles in a grant state without mem_ack before the transaction is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch read request; held with if_addr stable until if_ready
- if_addr  in  WIDTH  fetch address
- if_rdata  out  WIDTH  fetch read data; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held with addr/we/wdata/mode stable until dm_ready
- dm_we  in  1  1=store, 0=load
- dm_addr  in  WIDTH  data address
- dm_wdata  in  WIDTH  store data
- dm_mode  in  3  address mode (byte/half/word), passed through unchanged
- dm_rdata  out  WIDTH  load data; valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req & ~if_ready
- stall_dm  out  1  dm_req & ~dm_ready
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_mode  out  3  memory address mode
- mem_rdata  in  WIDTH  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; sampled only when mem_req=1
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0 at a rising edge), regardless of state:
  - FSM goes to IDLE.
  - All outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_mode, if_ready, dm_ready, if_rdata, dm_rdata, bus_err.
  - Streak and timeout counters clear.
  - An outstanding mem_ack is discarded. A mem_ack seen in IDLE or RESP is ignored.
- FSM states and transitions: IDLE -> GRANT_I or GRANT_D -> RESP -> IDLE.
- IDLE arbitration, evaluated in the cycle a request is seen:
  - Only one request -> grant it.
  - Both requests -> grant data, unless the streak counter equals MAX_DATA_STREAK, in which case grant fetch.
  - No request -> stay in IDLE.
- Streak counter:
  - Increments on each data grant made while if_req=1, saturating at MAX_DATA_STREAK.
  - Clears on every fetch grant, and on any data grant made while if_req=0.
- Grant entry: mem_* outputs are registered from the winning port on the IDLE->GRANT edge. mem_req=1 from the first GRANT cycle. For a fetch grant, mem_we=0 and mem_mode=3'b010 (word).
- In GRANT_x:
  - mem_* is held constant and the timeout counter increments each cycle.
  - On mem_ack=1: capture mem_rdata into x_rdata, move to RESP, drop mem_req on the same edge.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: move to RESP with x_rdata=0, set bus_err (cleared only by reset), drop mem_req.
- RESP: x_ready=1 for exactly one cycle, then IDLE. x_rdata holds its value until the next capture. A store also pulses dm_ready.
- Latency: request first seen in cycle t, ack in cycle t+1+L (L≥0 cycles of memory wait) -> ready in cycle t+2+L.
  - Minimum 3 cycles between successive grants (IDLE, GRANT, RESP).
- Requests:
  - A requester still asserting x_req in the cycle after its ready is issuing a new request.
  - A requester that drops x_req before ready violates the protocol; the arbiter completes the transaction anyway and pulses ready.
- The losing requester's stall stays high across the whole other transaction.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, GRANT_I, GRANT_D, RESP), port-select encoding, fetch mode constant 3'b010.
- One natural sub-module: arb_priority_sel. It is combinational and produces the grant decision from if_req, dm_req and streak_full.
- FSM, counters and registers stay in mem_port_arbiter.

Test Plan:
- Lone fetch: if_req=1, if_addr=0xBFC00000, ack 2 cycles after mem_req rises with rdata=0x00500093 -> if_ready pulse 3 cycles after mem_req rises, if_rdata=0x00500093, mem_we=0, mem_mode=010.
- Simultaneous requests: both requests at one cycle, dm_we=1, dm_addr=0x10000, dm_wdata=0xDEADBEEF, ack after 1 cycle -> data granted first, mem_we=1, mem_wdata=0xDEADBEEF; after dm_ready, fetch is granted in the next IDLE.
- Starvation: if_req held, dm_req re-asserted continuously, MAX_DATA_STREAK=4 -> exactly 4 data grants, then a fetch grant, then data resumes.
- Timeout: mem_ack held 0, TIMEOUT_CYCLES=8 -> mem_req high for exactly 8 cycles, dm_ready pulse with dm_rdata=0, bus_err=1 and sticky.
- Reset mid-transaction: rst=0 while in GRANT_D with mem_req=1 -> next cycle all outputs 0 and state IDLE; a late mem_ack is ignored and produces no ready.
- Back-to-back fetch: if_req held after ready with a new address, zero-wait ack -> grants spaced exactly 3 cycles apart, stall_if low only in the ready cycles.
